// File: rtl/gamma_loader.sv
// gamma_loader: fills the mixer gamma table with a linear ramp after reset, then
// streams user tables from the byte download, keeping en low while the table is partial.
module gamma_loader #(
  parameter int TBL_LEN = 768
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       gamma_req,
  input  logic       dl_start,
  input  logic       dl_valid,
  input  logic [7:0] dl_data,
  output logic       dl_ready,
  input  logic       dl_end,
  inout  wire [21:0] gamma_bus,
  output logic       busy,
  output logic       loaded,
  output logic       dl_err
);

  localparam logic [9:0] LAST = 10'(TBL_LEN - 1);
  localparam logic [9:0] FULL = 10'(TBL_LEN);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} state_t;

  state_t     state, state_d;
  logic [9:0] cnt, cnt_d, cnt_acc;
  logic       pend, pend_d;
  logic       loaded_d, err_d, ready_d;
  logic       take, present;
  logic       vld_d, vld_p1, en_p1;
  logic [9:0] addr_d, addr_p1;
  logic [7:0] val_d, val_p1;

  assign present = gamma_bus[21];
  assign take    = dl_valid & dl_ready;
  assign cnt_acc = take ? cnt + 10'd1 : cnt;

  assign gamma_bus[20:0] = {clk_sys, en_p1, vld_p1, addr_p1, val_p1};

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pend_d   = pend;
    loaded_d = loaded;
    err_d    = dl_err;
    vld_d    = 1'b0;
    addr_d   = addr_p1;
    val_d    = val_p1;
    if (dl_start) err_d = 1'b0;
    case (state)
      S_INIT: begin
        vld_d  = 1'b1;
        addr_d = cnt;
        val_d  = cnt[7:0];
        if (dl_start) pend_d = 1'b1;
        if (cnt == LAST) begin
          // A start seen during the ramp goes straight to LOAD, skipping IDLE.
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = (pend || dl_start) ? S_LOAD : S_IDLE;
        end else begin
          cnt_d = cnt + 10'd1;
        end
      end
      S_IDLE: begin
        if (dl_start) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (dl_start) begin
          cnt_d    = '0;
          loaded_d = 1'b0;
        end else begin
          if (take) begin
            vld_d  = 1'b1;
            addr_d = cnt;
            val_d  = dl_data;
          end
          cnt_d = cnt_acc;
          if (dl_end) begin
            // A byte accepted together with dl_end still counts toward a full table.
            cnt_d = '0;
            if (cnt_acc == FULL) begin
              loaded_d = 1'b1;
              state_d  = S_IDLE;
            end else begin
              err_d    = 1'b1;
              loaded_d = 1'b0;
              state_d  = S_INIT;
            end
          end
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == S_LOAD) && (cnt_d < FULL);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      cnt      <= '0;
      pend     <= 1'b0;
      loaded   <= 1'b0;
      dl_err   <= 1'b0;
      dl_ready <= 1'b0;
      busy     <= 1'b1;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      val_p1   <= '0;
      en_p1    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pend     <= pend_d;
      loaded   <= loaded_d;
      dl_err   <= err_d;
      dl_ready <= ready_d;
      busy     <= (state != S_IDLE);
      // bus stage p1: write strobe, address, value and enable all leave registered
      vld_p1   <= vld_d;
      addr_p1  <= addr_d;
      val_p1   <= val_d;
      en_p1    <= gamma_req & present & (state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_gamma_loader.sv
// Directed bench for gamma_loader: ramp, enable gating, downloads, overflow and resets.
module tb_gamma_loader;

  localparam int TBL = 768;

  logic       clk, reset, gamma_req, dl_start, dl_valid, dl_end, present;
  logic [7:0] dl_data;
  logic       dl_ready, busy, loaded, dl_err;
  wire [21:0] gamma_bus;

  wire       en   = gamma_bus[19];
  wire       vld  = gamma_bus[18];
  wire [9:0] addr = gamma_bus[17:8];
  wire [7:0] val  = gamma_bus[7:0];

  assign gamma_bus[21] = present;

  int errors = 0;
  int checks = 0;

  gamma_loader #(.TBL_LEN(TBL)) dut (
    .clk_sys(clk), .reset(reset), .gamma_req(gamma_req),
    .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data),
    .dl_ready(dl_ready), .dl_end(dl_end), .gamma_bus(gamma_bus),
    .busy(busy), .loaded(loaded), .dl_err(dl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Steps through a 768-entry ramp; counts entries that are not addr=i, value=i&FF.
  task automatic run_ramp(input int start_at, output int bad, output logic [7:0] v300);
    bad = 0;
    v300 = 8'h00;
    for (int i = 0; i < TBL; i++) begin
      @(negedge clk);
      dl_start = (i == start_at);
      if (i == 300) v300 = val;
      if (vld !== 1'b1 || addr !== 10'(i) || val !== i[7:0] || busy !== 1'b1 || en !== 1'b0)
        bad++;
    end
    dl_start = 1'b0;
  endtask

  // Offers n bytes 0xFF-(i&FF); tracks every bus write against the accepted handshakes.
  task automatic send_bytes(input int n, input bit gaps, output int writes, output int bad);
    int  sent, cyc;
    bit  acc_prev;
    sent = 0; cyc = 0; acc_prev = 1'b0; writes = 0; bad = 0;
    while ((sent < n || acc_prev) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (vld === 1'b1) begin
        if (!acc_prev || addr !== 10'(writes) || val !== (8'hFF - writes[7:0])) bad++;
        writes++;
        if (writes == TBL && dl_ready !== 1'b0) bad++;
      end else if (acc_prev) begin
        bad++;
      end
      if (sent < n) begin
        dl_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        dl_data  = 8'hFF - sent[7:0];
        if (dl_valid) sent++;
      end else begin
        dl_valid = 1'b0;
      end
      acc_prev = dl_valid && dl_ready;
    end
    if (cyc >= 4000) bad++;
    dl_valid = 1'b0;
    @(negedge clk);
    if (vld !== 1'b0) bad++;
  endtask

  task automatic start_dl();
    dl_start = 1'b1;
    @(negedge clk);
    dl_start = 1'b0;
  endtask

  task automatic end_dl();
    dl_end = 1'b1;
    @(negedge clk);
    dl_end = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_wr: got %0b want 0", vld); end
    checks++; if (addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
    checks++; if (val !== 8'h00) begin errors++; $display("FAIL reset_val: got %0h want 0", val); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", en); end
    checks++; if (dl_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", dl_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b want 1", busy); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %0b want 0", loaded); end
    checks++; if (dl_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", dl_err); end
    reset = 1'b0;
  endtask

  task automatic test_init_ramp();
    int bad; logic [7:0] v300;
    run_ramp(-1, bad, v300);
    checks++; if (bad !== 0) begin errors++; $display("FAIL ramp_entries: got %0d bad want 0", bad); end
    checks++; if (v300 !== 8'h2C) begin errors++; $display("FAIL ramp_addr300: got %0h want 2c", v300); end
    @(negedge clk);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL ramp_end_wr: got %0b want 0", vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_end_busy: got %0b want 0", busy); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL ramp_end_en: got %0b want 0", en); end
  endtask

  task automatic test_gamma_en();
    gamma_req = 1'b1; present = 1'b1;
    @(negedge clk);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL en_on: got %0b want 1", en); end
    present = 1'b0;
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL en_absent: got %0b want 0", en); end
    present = 1'b1; gamma_req = 1'b0;
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL en_noreq: got %0b want 0", en); end
    gamma_req = 1'b1;
    end_dl();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_end_busy: got %0b want 0", busy); end
    checks++; if (dl_ready !== 1'b0) begin errors++; $display("FAIL idle_end_ready: got %0b want 0", dl_ready); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL idle_end_en: got %0b want 1", en); end
  endtask

  task automatic test_download();
    int w, b;
    start_dl();
    checks++; if (dl_ready !== 1'b1) begin errors++; $display("FAIL dl_ready_up: got %0b want 1", dl_ready); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL dl_en_first: got %0b want 1", en); end
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL dl_en_drop: got %0b want 0", en); end
    send_bytes(TBL, 1'b1, w, b);
    checks++; if (w !== TBL) begin errors++; $display("FAIL dl_writes: got %0d want 768", w); end
    checks++; if (b !== 0) begin errors++; $display("FAIL dl_bad: got %0d want 0", b); end
    checks++; if (dl_ready !== 1'b0) begin errors++; $display("FAIL dl_full_ready: got %0b want 0", dl_ready); end
    end_dl();
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL dl_loaded: got %0b want 1", loaded); end
    checks++; if (dl_err !== 1'b0) begin errors++; $display("FAIL dl_err_clear: got %0b want 0", dl_err); end
    @(negedge clk);
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL dl_en_back: got %0b want 1", en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dl_busy_low: got %0b want 0", busy); end
  endtask

  task automatic test_short();
    int w, b, bad; logic [7:0] v300;
    start_dl();
    send_bytes(100, 1'b0, w, b);
    checks++; if (w !== 100) begin errors++; $display("FAIL short_writes: got %0d want 100", w); end
    checks++; if (b !== 0) begin errors++; $display("FAIL short_bad: got %0d want 0", b); end
    end_dl();
    checks++; if (dl_err !== 1'b1) begin errors++; $display("FAIL short_err: got %0b want 1", dl_err); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL short_loaded: got %0b want 0", loaded); end
    run_ramp(-1, bad, v300);
    checks++; if (bad !== 0) begin errors++; $display("FAIL short_ramp: got %0d bad want 0", bad); end
    @(negedge clk);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL short_idle_wr: got %0b want 0", vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_idle_busy: got %0b want 0", busy); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL short_idle_en: got %0b want 1", en); end
  endtask

  task automatic test_pending_start();
    int bad; logic [7:0] v300;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_ramp(10, bad, v300);
    checks++; if (bad !== 0) begin errors++; $display("FAIL pend_ramp: got %0d bad want 0", bad); end
    @(negedge clk);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL pend_wr: got %0b want 0", vld); end
    checks++; if (dl_ready !== 1'b1) begin errors++; $display("FAIL pend_ready: got %0b want 1", dl_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_busy: got %0b want 1", busy); end
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL pend_en: got %0b want 0", en); end
  endtask

  task automatic test_overflow();
    int w, b;
    send_bytes(TBL + 2, 1'b0, w, b);
    checks++; if (w !== TBL) begin errors++; $display("FAIL ovf_writes: got %0d want 768", w); end
    checks++; if (b !== 0) begin errors++; $display("FAIL ovf_bad: got %0d want 0", b); end
    checks++; if (dl_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %0b want 0", dl_ready); end
    end_dl();
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL ovf_loaded: got %0b want 1", loaded); end
  endtask

  task automatic test_reset_mid_load();
    int w, b, bad; logic [7:0] v300;
    start_dl();
    send_bytes(400, 1'b1, w, b);
    checks++; if (w !== 400) begin errors++; $display("FAIL mid_writes: got %0d want 400", w); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (dl_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b want 0", dl_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy: got %0b want 1", busy); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_loaded: got %0b want 0", loaded); end
    reset = 1'b0;
    run_ramp(-1, bad, v300);
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_ramp: got %0d bad want 0", bad); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy: got %0b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1; gamma_req = 1'b0; present = 1'b1;
    dl_start = 1'b0; dl_valid = 1'b0; dl_end = 1'b0; dl_data = 8'h00;
    test_reset();
    test_init_ramp();
    test_gamma_en();
    test_download();
    test_short();
    test_pending_start();
    test_overflow();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
